// File: rtl/comparator_pkg.sv
// comparator_pkg: shared width default and compare result encoding.
package comparator_pkg;
  localparam int DEFAULT_WIDTH = 3;
  typedef enum logic [1:0] {CMP_EQ, CMP_GT, CMP_LT} cmp_result_t;
endpackage

// File: rtl/comparator_core.sv
// comparator_core: combinational magnitude compare, unsigned or two's complement.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output cmp_result_t      o_res
);
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] FLIP = SIGNED_CMP ? MSB : '0;
  logic [WIDTH-1:0] w_xa, w_ya;
  assign w_xa = x ^ FLIP;
  assign w_ya = y ^ FLIP;
  assign o_res = (x == y) ? CMP_EQ : (w_xa > w_ya) ? CMP_GT : CMP_LT;
endmodule

// File: rtl/comparator.sv
// comparator: registers the core's compare result as one-hot eq/gt/lt flags.
module comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             eqo,
  output logic             gto,
  output logic             lto
);
  cmp_result_t w_res;
  comparator_core #(.WIDTH(WIDTH), .SIGNED_CMP(SIGNED_CMP)) u_core (
    .x     (x),
    .y     (y),
    .o_res (w_res)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eqo <= 1'b0;
      gto <= 1'b0;
      lto <= 1'b0;
    end else begin
      eqo <= (w_res == CMP_EQ);
      gto <= (w_res == CMP_GT);
      lto <= (w_res == CMP_LT);
    end
  end
endmodule

// File: tb/tb_comparator.sv
// tb_comparator: checks unsigned and signed comparators against an integer model.
module tb_comparator;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] x = '0, y = '0;
  logic       eqo_u, gto_u, lto_u, eqo_s, gto_s, lto_s;
  logic [2:0] f_u, f_s;
  logic [2:0] exp_u = '0, exp_s = '0;
  int         vectors = 0, miscompares = 0;
  bit         run = 1'b0;

  comparator #(.WIDTH(3), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .eqo(eqo_u), .gto(gto_u), .lto(lto_u));
  comparator #(.WIDTH(3), .SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .eqo(eqo_s), .gto(gto_s), .lto(lto_s));

  assign f_u = {eqo_u, gto_u, lto_u};
  assign f_s = {eqo_s, gto_s, lto_s};

  always #5 clk = ~clk;

  // Returns {eq, gt, lt} from plain integer comparison of the operand values.
  function automatic logic [2:0] ref_flags(logic [2:0] a, logic [2:0] b, bit sg);
    int av = int'(a);
    int bv = int'(b);
    if (sg && a[2]) av -= 8;
    if (sg && b[2]) bv -= 8;
    return {av == bv, av > bv, av < bv};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exp_u <= '0;
      exp_s <= '0;
    end else begin
      exp_u <= ref_flags(x, y, 1'b0);
      exp_s <= ref_flags(x, y, 1'b1);
    end

  task automatic check3(string name, logic [2:0] got, logic [2:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got eq/gt/lt=%b want %b at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk)
    if (run) begin
      check3("model_u", f_u, exp_u);
      check3("model_s", f_s, exp_s);
      if (rst_n && exp_u != '0) begin
        vectors++;
        if (!$onehot(f_u) || !$onehot(f_s)) begin
          miscompares++;
          $display("FAIL onehot: got u=%b s=%b want one-hot at %0t", f_u, f_s, $time);
        end
      end
    end

  task automatic apply(logic [2:0] a, logic [2:0] b);
    @(negedge clk);
    #2;
    x = a;
    y = b;
  endtask

  task automatic edge_check(string name, logic [2:0] wu, logic [2:0] ws);
    @(posedge clk);
    #1;
    check3({name, "_u"}, f_u, wu);
    check3({name, "_s"}, f_s, ws);
  endtask

  initial begin
    rst_n = 1'b0;
    #1;
    run = 1'b1;
    check3("reset_u", f_u, 3'b000);
    check3("reset_s", f_s, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(3'b000, 3'b000); edge_check("zero_eq", 3'b100, 3'b100);
    apply(3'b001, 3'b010); edge_check("1_lt_2", 3'b001, 3'b001);
    apply(3'b100, 3'b100); edge_check("4_eq_4", 3'b100, 3'b100);
    apply(3'b100, 3'b011); edge_check("4_vs_3", 3'b010, 3'b001);
    apply(3'b011, 3'b100); edge_check("3_vs_4", 3'b001, 3'b010);
    apply(3'b111, 3'b000); edge_check("ones_vs_zero", 3'b010, 3'b001);
    apply(3'b111, 3'b111); edge_check("ones_eq", 3'b100, 3'b100);
    // Asynchronous clear between edges, then recovery on the next edge.
    apply(3'b101, 3'b101); edge_check("pre_rst", 3'b100, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    check3("async_rst_u", f_u, 3'b000);
    check3("async_rst_s", f_s, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    x = 3'b111;
    y = 3'b111;
    #1;
    check3("held_rst_u", f_u, 3'b000);
    edge_check("post_rst", 3'b100, 3'b100);
    // Inputs moving mid-cycle must not reach the flags before the next edge.
    apply(3'b010, 3'b101); edge_check("mid_a", 3'b001, 3'b010);
    #2;
    x = 3'b101;
    y = 3'b010;
    #1;
    check3("mid_hold_u", f_u, 3'b001);
    check3("mid_hold_s", f_s, 3'b010);
    edge_check("mid_b", 3'b010, 3'b001);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        apply(3'(a), 3'(b));
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 Parameter WIDTH, default 3: operand width in bits, legal range 1..32.
REQ-002 Parameter SIGNED_CMP, default 0: 0 = unsigned magnitude compare, 1 = two's-complement compare.
REQ-003 clk  input  1  single clock for all state, rising-edge active.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 x  input  WIDTH  operand A.
REQ-006 y  input  WIDTH  operand B.
REQ-007 eqo  output  1  registered flag, high when x == y.
REQ-008 gto  output  1  registered flag, high when x > y under the selected signedness.
REQ-009 lto  output  1  registered flag, high when x < y under the selected signedness.

Function
REQ-010 Compare x and y combinationally each cycle and register the result on the rising edge of clk; all outputs have exactly 1-cycle latency from the sampled inputs.
REQ-011 eqo SHALL be a bitwise equality of all WIDTH bits and SHALL be independent of SIGNED_CMP.
REQ-012 Exactly one of eqo, gto, lto SHALL be high in every cycle after the first clock edge following reset release (one-hot result).
REQ-013 With SIGNED_CMP=0, compare as unsigned integers 0..2^WIDTH-1.
REQ-014 With SIGNED_CMP=1, the MSB is the sign bit; negative values compare less than all non-negative values; most-negative vs most-positive SHALL give lto=1.
REQ-015 Boundary cases: all-zeros vs all-zeros gives eqo=1; all-ones vs all-ones gives eqo=1; all-ones vs all-zeros gives gto=1 when unsigned and lto=1 when signed.
REQ-016 Input changes between clock edges SHALL NOT affect the outputs until the next rising edge (no glitch propagation to outputs).
REQ-017 No state other than the three output registers; no handshake; a new compare is accepted every cycle.

Reset
REQ-018 While rst_n=0, eqo, gto and lto SHALL be 0, asserted asynchronously without waiting for clk.
REQ-019 Reset asserted mid-operation SHALL clear all outputs immediately; the first valid result SHALL appear on the first rising edge after rst_n returns high.
REQ-020 Reset deassertion is synchronised externally; the block performs no internal reset synchronisation.

Structure
REQ-021 Shared package comparator_pkg SHALL hold the default WIDTH constant and the enum cmp_result_t {CMP_EQ, CMP_GT, CMP_LT}.
REQ-022 One sub-module, comparator_core, SHALL be purely combinational: it takes x, y and SIGNED_CMP and returns a cmp_result_t.
REQ-023 The top level SHALL instantiate comparator_core and decode its result into the three registered flags.
REQ-024 No latches, and no use of X or Z on outputs under any input.

Verification
REQ-025 Reset release, then x=000, y=000 -> after 1 edge eqo=1, gto=0, lto=0.
REQ-026 x=001, y=010 (unsigned) -> after 1 edge eqo=0, lto=1, gto=0.
REQ-027 x=100, y=100 -> after 1 edge eqo=1; then x=100, y=011: with SIGNED_CMP=0 gto=1, with SIGNED_CMP=1 lto=1.
REQ-028 Assert rst_n=0 between clock edges while eqo=1 -> eqo=gto=lto=0 immediately; release reset and drive x=y=111 -> eqo=1 after the next edge.
REQ-029 Exhaustive sweep of all 64 (x,y) pairs for WIDTH=3, in both signedness modes -> flags match a reference model, with one-hot held every cycle.
REQ-030 Change inputs mid-cycle -> outputs remain stable until the next rising edge.
